// File: rtl/sbp_pkg.sv
// Shared definitions for the scalable pipelined lookup chain: stage-bus field widths,
// result-width derivation and the slot record carried between stages.
package sbp_pkg;

    localparam int BIT_POS_BITS      = 6;
    localparam int DEF_STAGE_ID_BITS = 6;
    localparam int DEF_LOCATION_BITS = 11;
    localparam int DEF_PAD_BITS      = 4;

    function automatic int pad_to(input int bits, input int unit);
        return ((bits + unit - 1) / unit) * unit;
    endfunction

    // A result holds a padded child stage id, a padded child location and one flag nibble.
    function automatic int result_bits(input int stage_id_bits, input int location_bits,
                                       input int unit);
        return pad_to(stage_id_bits, unit) + pad_to(location_bits, unit) + unit;
    endfunction

    localparam int DEF_RESULT_BITS = result_bits(DEF_STAGE_ID_BITS, DEF_LOCATION_BITS, DEF_PAD_BITS);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_UPDATE = 1'b1
    } ingress_state_t;

    typedef struct packed {
        logic                         update;
        logic [31:0]                  ip_addr;
        logic [BIT_POS_BITS-1:0]      bit_pos;
        logic [DEF_STAGE_ID_BITS-1:0] stage_id;
        logic [DEF_LOCATION_BITS-1:0] location;
        logic [DEF_RESULT_BITS-1:0]   result;
        logic                         valid;
    } slot_t;

endpackage

// File: rtl/sbp_credit_counter.sv
// Saturating up/down credit counter; a return while already full is dropped and
// latches a sticky error flag.
module sbp_credit_counter #(
    parameter int MAX_COUNT  = 16,
    parameter int COUNT_BITS = $clog2(MAX_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_inc,
    input  logic                  i_dec,
    output logic [COUNT_BITS-1:0] o_count,
    output logic                  o_err
);

    logic [COUNT_BITS-1:0] r_count;
    logic                  r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= COUNT_BITS'(MAX_COUNT);
            r_err   <= 1'b0;
        end else begin
            case ({i_inc, i_dec})
                2'b10: begin
                    if (r_count == COUNT_BITS'(MAX_COUNT)) begin
                        r_err <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                2'b01: begin
                    if (r_count != '0) begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

// File: rtl/sbp_lookup_ingress.sv
// Ingress of the lookup chain: merges lookups and table-update bursts onto the
// one-slot-per-cycle stage bus, framing each burst with a guard idle and a trailer.
module sbp_lookup_ingress
    import sbp_pkg::*;
#(
    parameter int STAGE_ID_BITS = 6,
    parameter int LOCATION_BITS = 11,
    parameter int PAD_BITS      = 4,
    parameter int ROOT_STAGE_ID = 1,
    parameter int PIPE_CREDITS  = 16,
    parameter int UPD_BURST_MAX = 8,
    parameter int RESULT_BITS   = result_bits(STAGE_ID_BITS, LOCATION_BITS, PAD_BITS),
    parameter int CREDIT_BITS   = $clog2(PIPE_CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lookup_valid_i,
    output logic                     lookup_ready_o,
    input  logic [31:0]              lookup_ip_addr_i,
    input  logic                     upd_valid_i,
    output logic                     upd_ready_o,
    input  logic [31:0]              upd_prefix_i,
    input  logic [5:0]               upd_prefix_length_i,
    input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
    input  logic [LOCATION_BITS-1:0] upd_location_i,
    input  logic [RESULT_BITS-1:0]   upd_result_i,
    input  logic                     credit_return_i,
    output logic                     update_o,
    output logic [31:0]              ip_addr_o,
    output logic [5:0]               bit_pos_o,
    output logic [STAGE_ID_BITS-1:0] stage_id_o,
    output logic [LOCATION_BITS-1:0] location_o,
    output logic [RESULT_BITS-1:0]   result_o,
    output logic                     valid_o,
    output logic [CREDIT_BITS-1:0]   credits_o,
    output logic                     credit_err_o
);

    localparam int BURST_BITS = $clog2(UPD_BURST_MAX + 1);

    ingress_state_t          r_state;
    logic                    r_fair;
    logic [BURST_BITS-1:0]   r_burst_cnt;

    logic                    r_update;
    logic [31:0]             r_ip_addr;
    logic [5:0]              r_bit_pos;
    logic [STAGE_ID_BITS-1:0] r_stage_id;
    logic [LOCATION_BITS-1:0] r_location;
    logic [RESULT_BITS-1:0]  r_result;
    logic                    r_valid;

    logic                    w_credits_avail;
    logic                    w_lookup_fire;
    logic                    w_upd_fire;

    assign w_credits_avail = (credits_o != '0);
    assign lookup_ready_o  = (r_state == ST_RUN) && !(upd_valid_i && !r_fair) && w_credits_avail;
    assign upd_ready_o     = (r_state == ST_UPDATE) && (r_burst_cnt < BURST_BITS'(UPD_BURST_MAX));
    assign w_lookup_fire   = lookup_valid_i && lookup_ready_o;
    assign w_upd_fire      = upd_valid_i && upd_ready_o;

    sbp_credit_counter #(
        .MAX_COUNT  (PIPE_CREDITS),
        .COUNT_BITS (CREDIT_BITS)
    ) u_credits (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (credit_return_i),
        .i_dec   (w_lookup_fire),
        .o_count (credits_o),
        .o_err   (credit_err_o)
    );

    // The fairness flag lets one lookup slip in after each burst so a steady update
    // stream cannot starve lookups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_fair      <= 1'b0;
            r_burst_cnt <= '0;
            r_update    <= 1'b0;
            r_ip_addr   <= '0;
            r_bit_pos   <= '0;
            r_stage_id  <= '0;
            r_location  <= '0;
            r_result    <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_update   <= 1'b0;
            r_ip_addr  <= '0;
            r_bit_pos  <= '0;
            r_stage_id <= '0;
            r_location <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (upd_valid_i && !r_fair) begin
                        r_state     <= ST_UPDATE;
                        r_burst_cnt <= '0;
                    end else begin
                        if (w_lookup_fire) begin
                            r_valid    <= 1'b1;
                            r_ip_addr  <= lookup_ip_addr_i;
                            r_stage_id <= STAGE_ID_BITS'(ROOT_STAGE_ID);
                            r_fair     <= 1'b0;
                        end
                        if (!lookup_valid_i || !w_credits_avail) begin
                            r_fair <= 1'b0;
                        end
                    end
                end
                ST_UPDATE: begin
                    r_update <= 1'b1;
                    if (w_upd_fire) begin
                        r_ip_addr   <= upd_prefix_i;
                        r_bit_pos   <= upd_prefix_length_i;
                        r_stage_id  <= upd_stage_id_i;
                        r_location  <= upd_location_i;
                        r_result    <= upd_result_i;
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                        r_fair  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign update_o   = r_update;
    assign ip_addr_o  = r_ip_addr;
    assign bit_pos_o  = r_bit_pos;
    assign stage_id_o = r_stage_id;
    assign location_o = r_location;
    assign result_o   = r_result;
    assign valid_o    = r_valid;

endmodule
